// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified-memory port arbiter:
//   - FSM state encoding (ST_IDLE / ST_BUSY / ST_RESP)
//   - access size codes (SZ_B / SZ_H / SZ_W, SZ_ILL is the illegal code)
//   - requester identifiers (OWN_IF / OWN_LS)
//   - latched request record and address-check helpers
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_ILL = 2'd3;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    // Fields of the winning request, held for the whole memory access.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Byte address beyond the end of a 2^addr_w-word memory.
    // A 33-bit limit keeps addr_w up to 30 representable.
    function automatic logic addr_oob(input logic [31:0] addr, input int unsigned addr_w);
        logic [32:0] lim;
        lim = 33'd1 << (addr_w + 2);
        return ({1'b0, addr} >= lim);
    endfunction

    // Alignment / size legality of a load/store; bytes may sit anywhere.
    function automatic logic ls_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lsb[0];
            SZ_W:    bad = (lsb != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// ---------------------------------------------------------------------------
// arb_starve_ctr
// Saturating up-counter with synchronous clear. Used both for the IF
// starvation count and for the memory-ready timeout count.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset
//   inc    in   count up by one (holds at LIM)
//   clr    in   clear to zero (wins over inc)
//   at_lim out  counter equals LIM
// ---------------------------------------------------------------------------
module arb_starve_ctr #(
    parameter int unsigned LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_lim
);

    localparam int unsigned W = (LIM < 1) ? 1 : $clog2(LIM + 1);
    localparam logic [W-1:0] LIM_V = W'(LIM);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != LIM_V)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign at_lim = (cnt_q == LIM_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between the CPU fetch port (IF) and the
// load/store port (LS). LS has fixed priority; IF is forced through after
// STARVE_LIM lost arbitrations. Misaligned, out-of-range and illegal-size
// requests are answered with err without touching memory; an access that
// sees no mem_ready for TIMEOUT cycles is aborted with err.
//
// Build option: define ARB_STATS_EN to enable the grant counters behind
// stat_if_cnt / stat_ls_cnt (otherwise they are tied to zero).
//
// Handshake: a requester holds req (and its fields) until it sees a
// one-cycle gnt in the same cycle; exactly one rvalid pulse (with
// rdata/err) follows later. gnt and rvalid never go to both ports in the
// same cycle. mem_en is held with stable fields until mem_ready.
//
// Ports:
//   clk, rst                     clock, async active-low reset
//   if_req/if_addr               fetch request (word reads)
//   if_gnt/if_rvalid/if_rdata/if_err   fetch grant and response
//   ls_req/ls_we/ls_size/ls_addr/ls_wdata  load/store request
//   ls_gnt/ls_rvalid/ls_rdata/ls_err   load/store grant and response
//   mem_en/mem_we/mem_size/mem_addr/mem_wdata  memory access
//   mem_rdata/mem_ready          memory response
//   stat_if_cnt/stat_ls_cnt      grant counters (ARB_STATS_EN)
//   dbg_state                    current FSM state
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned STARVE_LIM = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] stat_if_cnt,
    output logic [31:0] stat_ls_cnt,
    output logic [1:0]  dbg_state
);

    state_t      state_q, state_d;
    owner_t      owner_q;
    req_t        req_q, win_req;
    logic        err_q;
    logic [31:0] rdata_q;

    logic arb_cycle, pick_if, pick_ls, win_bad;
    logic if_bad, ls_bad;
    logic starve_at_lim, to_at_lim;
    logic busy;

    assign busy = (state_q == ST_BUSY);

    // Arbitration happens in IDLE and overlapped with RESP. Gating with rst
    // keeps gnt low while reset is held even if a request is present.
    assign arb_cycle = rst && ((state_q == ST_IDLE) || (state_q == ST_RESP));

    always_comb begin
        pick_if = 1'b0;
        pick_ls = 1'b0;
        if (arb_cycle) begin
            if (if_req && (starve_at_lim || !ls_req)) begin
                pick_if = 1'b1;
            end else if (ls_req) begin
                pick_ls = 1'b1;
            end
        end
    end

    assign if_bad  = addr_oob(if_addr, ADDR_W) || (if_addr[1:0] != 2'b00);
    assign ls_bad  = addr_oob(ls_addr, ADDR_W) || ls_misaligned(ls_size, ls_addr[1:0]);
    assign win_bad = pick_ls ? ls_bad : if_bad;

    always_comb begin
        win_req = '0;
        if (pick_ls) begin
            win_req.we    = ls_we;
            win_req.size  = ls_size;
            win_req.addr  = ls_addr;
            win_req.wdata = ls_wdata;
        end else begin
            win_req.we    = 1'b0;
            win_req.size  = SZ_W;
            win_req.addr  = if_addr;
            win_req.wdata = 32'd0;
        end
    end

    // IF starvation: counts arbitrations IF lost while asking.
    arb_starve_ctr #(.LIM(STARVE_LIM)) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (arb_cycle && if_req && pick_ls),
        .clr    (!if_req || pick_if),
        .at_lim (starve_at_lim)
    );

    // Timeout: at_lim on the TIMEOUT-th BUSY cycle without mem_ready.
    arb_starve_ctr #(.LIM(TIMEOUT - 1)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .inc    (busy && !mem_ready),
        .clr    (!busy),
        .at_lim (to_at_lim)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (pick_if || pick_ls) begin
                    state_d = win_bad ? ST_RESP : ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mem_ready || to_at_lim) begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        if_gnt    = pick_if;
        ls_gnt    = pick_ls;
        if_rvalid = 1'b0;
        if_rdata  = 32'd0;
        if_err    = 1'b0;
        ls_rvalid = 1'b0;
        ls_rdata  = 32'd0;
        ls_err    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (state_q == ST_RESP) begin
            if (owner_q == OWN_IF) begin
                if_rvalid = 1'b1;
                if_rdata  = rdata_q;
                if_err    = err_q;
            end else begin
                ls_rvalid = 1'b1;
                ls_rdata  = rdata_q;
                ls_err    = err_q;
            end
        end
        if (busy) begin
            mem_en    = 1'b1;
            mem_we    = req_q.we;
            mem_size  = req_q.size;
            mem_addr  = req_q.addr;
            mem_wdata = req_q.wdata;
        end
    end

    assign dbg_state = state_q;

    // ---------------- Request / response datapath ----------------
    // rdata is zeroed at grant so error-checked and timed-out accesses
    // answer with 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_IF;
            req_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else if (pick_if || pick_ls) begin
            owner_q <= pick_ls ? OWN_LS : OWN_IF;
            req_q   <= win_req;
            err_q   <= win_bad;
            rdata_q <= 32'd0;
        end else if (busy) begin
            if (mem_ready) begin
                rdata_q <= mem_rdata;
                err_q   <= 1'b0;
            end else if (to_at_lim) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b1;
            end
        end
    end

    // ---------------- Grant statistics ----------------
`ifdef ARB_STATS_EN
    logic [31:0] if_cnt_q, ls_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_cnt_q <= 32'd0;
            ls_cnt_q <= 32'd0;
        end else begin
            if (if_gnt) if_cnt_q <= if_cnt_q + 32'd1;
            if (ls_gnt) ls_cnt_q <= ls_cnt_q + 32'd1;
        end
    end

    assign stat_if_cnt = if_cnt_q;
    assign stat_ls_cnt = ls_cnt_q;
`else
    assign stat_if_cnt = 32'd0;
    assign stat_ls_cnt = 32'd0;
`endif

endmodule
